// File: rtl/snow64_lar_wb_bridge_pkg.sv
// Shared types and widths for the LAR write-back bridge.
// Holds the line/address widths used by the LAR file side, the beat index
// type, the serializer FSM state encoding and the queue-depth derived widths.
package PkgSnow64LarWbBridge;

  localparam int LINE_W        = 256;
  localparam int BASE_ADDR_W   = 59;
  localparam int CPU_ADDR_W    = 64;
  localparam int DEFAULT_DEPTH = 4;

  typedef logic [CPU_ADDR_W-1:0] CpuAddr;
  typedef logic [1:0]            LarWbBeatIndex;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } LarWbState;

  // Pointer width for a power-of-two queue; a one-entry queue still needs one bit.
  function automatic int lar_wb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must be able to hold DEPTH itself.
  function automatic int lar_wb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/snow64_lar_wb_bridge_serializer.sv
// Snow64LarWbSerializer: turns the current head line into four 64-bit beats.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   send_d_i        FSM will be in SEND after this edge
//   start_i         restart the beat counter at beat 0 (new head line)
//   line_data_i     next-state head line data
//   base_addr_i     next-state head line base address
//   in_bus_ack      memory accepts the presented beat
//   line_done_o     last beat is being accepted this cycle
//   out_bus_*       registered beat valid / address / data / last
module Snow64LarWbSerializer
  import PkgSnow64LarWbBridge::*;
#(
  parameter int BEAT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send_d_i,
  input  logic                   start_i,
  input  logic [LINE_W-1:0]      line_data_i,
  input  logic [BASE_ADDR_W-1:0] base_addr_i,
  input  logic                   in_bus_ack,
  output logic                   line_done_o,
  output logic                   out_bus_req,
  output CpuAddr                 out_bus_addr,
  output logic [BEAT_WIDTH-1:0]  out_bus_data,
  output logic                   out_bus_last
);

  LarWbBeatIndex         beat_q, beat_d;
  logic                  req_q;
  CpuAddr                addr_q, addr_d;
  logic [BEAT_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  always_comb begin
    line_done_o = req_q && in_bus_ack && (beat_q == 2'd3);

    beat_d = beat_q;
    if (start_i || !send_d_i) begin
      beat_d = '0;
    end else if (req_q && in_bus_ack) begin
      beat_d = beat_q + 2'd1;
    end

    // Outputs are computed from next-state values so they are valid the
    // cycle the FSM enters SEND; without an ack nothing upstream changes,
    // so the registered beat holds steady.
    addr_d = '0;
    data_d = '0;
    last_d = 1'b0;
    if (send_d_i) begin
      addr_d = {base_addr_i, beat_d, 3'b000};
      data_d = line_data_i[beat_d * BEAT_WIDTH +: BEAT_WIDTH];
      last_d = (beat_d == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      req_q  <= send_d_i;
      addr_q <= addr_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign out_bus_req  = req_q;
  assign out_bus_addr = addr_q;
  assign out_bus_data = data_q;
  assign out_bus_last = last_q;

endmodule

// File: rtl/snow64_lar_wb_bridge.sv
// snow64_lar_wb_bridge: coalescing write-back queue between the LAR file and
// the memory controller. Dirty lines are queued (same-address requests merge
// into a waiting entry) and each line is sent as four beats on a valid/ack bus.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_mem_write_req/data/base_addr   one-cycle line write request
//   out_wb_full                all slots valid (LAR file must pause)
//   out_overflow               sticky: a request was dropped
//   out_idle                   queue empty and FSM idle
//   out_bus_req/addr/data/last beat valid, byte address, data, last beat
//   in_bus_ack                 memory accepts the current beat
module snow64_lar_wb_bridge
  import PkgSnow64LarWbBridge::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_mem_write_req,
  input  logic [LINE_W-1:0]      in_mem_write_data,
  input  logic [BASE_ADDR_W-1:0] in_mem_write_base_addr,
  output logic                   out_wb_full,
  output logic                   out_overflow,
  output logic                   out_idle,
  output logic                   out_bus_req,
  output CpuAddr                 out_bus_addr,
  output logic [BEAT_WIDTH-1:0]  out_bus_data,
  output logic                   out_bus_last,
  input  logic                   in_bus_ack
);

  localparam int PTR_W = lar_wb_ptr_w(DEPTH);
  localparam int CNT_W = lar_wb_cnt_w(DEPTH);

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [BASE_ADDR_W-1:0] addr_q [DEPTH];
  logic [BASE_ADDR_W-1:0] addr_d [DEPTH];
  logic [LINE_W-1:0]      data_q [DEPTH];
  logic [LINE_W-1:0]      data_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, hit_idx;
  logic [CNT_W-1:0]       count_q, count_d;
  LarWbState              state_q, state_d;
  logic                   full_q, ovf_q, idle_q, ovf_d;
  logic                   hit, alloc, drop, pop, start;

  always_comb begin
    // The head is frozen while it is being sent, so it never matches.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == in_mem_write_base_addr) &&
          !((state_q == SEND) && (PTR_W'(i) == head_q))) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end

    // Fullness uses the pre-edge count: a same-edge pop does not make room.
    alloc = in_mem_write_req && !hit && (count_q != CNT_W'(DEPTH));
    drop  = in_mem_write_req && !hit && (count_q == CNT_W'(DEPTH));
    ovf_d = ovf_q || drop;

    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (in_mem_write_req && hit) begin
      data_d[hit_idx] = in_mem_write_data;
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = in_mem_write_base_addr;
      data_d[tail_q]  = in_mem_write_data;
    end

    head_d  = pop   ? head_q + PTR_W'(1) : head_q;
    tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          start   = 1'b1;
        end
      end
      SEND: begin
        if (pop) begin
          if (count_d != '0) start = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      ovf_q   <= ovf_d;
      idle_q  <= (count_d == '0) && (state_d == IDLE);
    end
  end

  // Line storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  Snow64LarWbSerializer #(
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_serializer (
    .clk          (clk),
    .rst          (rst),
    .send_d_i     (state_d == SEND),
    .start_i      (start),
    .line_data_i  (data_d[head_d]),
    .base_addr_i  (addr_d[head_d]),
    .in_bus_ack   (in_bus_ack),
    .line_done_o  (pop),
    .out_bus_req  (out_bus_req),
    .out_bus_addr (out_bus_addr),
    .out_bus_data (out_bus_data),
    .out_bus_last (out_bus_last)
  );

  assign out_wb_full  = full_q;
  assign out_overflow = ovf_q;
  assign out_idle     = idle_q;

endmodule

// File: tb/tb_snow64_lar_wb_bridge.sv
module tb_snow64_lar_wb_bridge;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_mem_write_req = 1'b0;
  logic [255:0] in_mem_write_data = '0;
  logic [58:0]  in_mem_write_base_addr = '0;
  logic         out_wb_full, out_overflow, out_idle;
  logic         out_bus_req, out_bus_last;
  logic [63:0]  out_bus_addr, out_bus_data;
  logic         in_bus_ack = 1'b0;

  always #5 clk = ~clk;

  snow64_lar_wb_bridge #(.DEPTH(DEPTH), .BEAT_WIDTH(64)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_mem_write_req       (in_mem_write_req),
    .in_mem_write_data      (in_mem_write_data),
    .in_mem_write_base_addr (in_mem_write_base_addr),
    .out_wb_full            (out_wb_full),
    .out_overflow           (out_overflow),
    .out_idle               (out_idle),
    .out_bus_req            (out_bus_req),
    .out_bus_addr           (out_bus_addr),
    .out_bus_data           (out_bus_data),
    .out_bus_last           (out_bus_last),
    .in_bus_ack             (in_bus_ack)
  );

  typedef struct {
    logic [58:0]  a;
    logic [255:0] d;
  } line_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    bit          last;
  } beat_t;

  // Reference model: ordered list of pending lines (element 0 is the head),
  // whether the head is on the bus, and which beat is presented.
  line_t mq[$];
  beat_t exp_q[$];
  bit    m_send = 0;
  int    m_beat = 0;
  bit    m_ovf  = 0;
  bit    mon_en = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic void push_line(input line_t l);
    for (int b = 0; b < 4; b++) begin
      beat_t bt;
      bt.addr = {l.a, 5'b0} + 64'(8 * b);
      bt.data = l.d[64*b +: 64];
      bt.last = (b == 3);
      exp_q.push_back(bt);
    end
  endfunction

  function automatic void model_step(input bit r, input logic [58:0] a,
                                     input logic [255:0] d, input bit k);
    int  hit = -1;
    int  pre = mq.size();
    bit  pop = m_send && k && (m_beat == 3);
    if (r) begin
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].a == a && !(i == 0 && m_send)) hit = i;
      if (hit >= 0)             mq[hit].d = d;
      else if (pre < DEPTH)     mq.push_back('{a, d});
      else                      m_ovf = 1;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_beat = 0;
      if (mq.size() != 0) push_line(mq[0]);
      else                m_send = 0;
    end else if (!m_send) begin
      if (pre != 0) begin
        m_send = 1;
        m_beat = 0;
        push_line(mq[0]);
      end
    end else if (k) begin
      m_beat++;
    end
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick(input bit r, input logic [58:0] a, input logic [255:0] d, input bit k);
    in_mem_write_req       = r;
    in_mem_write_base_addr = a;
    in_mem_write_data      = d;
    in_bus_ack             = k;
    @(posedge clk);
    model_step(r, a, d, k);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || m_send) && n < 300) begin
      tick(0, '0, '0, 1);
      n++;
    end
    chk("drain_timeout", 64'(n >= 300), 64'd0);
    tick(0, '0, '0, 1);
    chk("exp_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: samples on the falling edge; a beat is accepted at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("bus_req",  64'(out_bus_req),  64'(m_send));
      chk("wb_full",  64'(out_wb_full),  64'(mq.size() == DEPTH));
      chk("overflow", 64'(out_overflow), 64'(m_ovf));
      chk("idle",     64'(out_idle),     64'(mq.size() == 0 && !m_send));
      if (out_bus_req && in_bus_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_bus_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_addr", out_bus_addr, e.addr);
          chk("beat_data", out_bus_data, e.data);
          chk("beat_last", 64'(out_bus_last), 64'(e.last));
        end
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_full", 64'(out_wb_full),  64'd0);
    chk("rst_ovf",  64'(out_overflow), 64'd0);
    chk("rst_idle", 64'(out_idle),     64'd1);
    chk("rst_req",  64'(out_bus_req),  64'd0);
    chk("rst_addr", out_bus_addr,      64'd0);
    chk("rst_data", out_bus_data,      64'd0);
    chk("rst_last", 64'(out_bus_last), 64'd0);
  endtask

  initial begin
    logic [255:0] l1;
    int stall;
    int n;

    #22;
    chk_reset_vals();
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1;

    // Single line: beats A,B,C,D at 0x20..0x38.
    l1 = {64'hD, 64'hC, 64'hB, 64'hA};
    tick(1, 59'h1, l1, 1);
    drain();

    // Stall for three cycles on beat 1.
    tick(1, 59'h1, rnd256(), 1);
    stall = 0;
    n = 0;
    while ((mq.size() != 0 || m_send) && n < 100) begin
      if (m_send && m_beat == 1 && stall < 3) begin
        stall++;
        tick(0, '0, '0, 0);
      end else begin
        tick(0, '0, '0, 1);
      end
      n++;
    end
    drain();

    // Coalesce into a waiting entry.
    tick(1, 59'h10, rnd256(), 0);
    tick(1, 59'h20, rnd256(), 0);
    tick(1, 59'h20, rnd256(), 0);
    tick(0, '0, '0, 0);
    drain();

    // Frozen head: same address during its transfer takes a new slot.
    tick(1, 59'h30, rnd256(), 0);
    tick(0, '0, '0, 0);
    tick(1, 59'h30, rnd256(), 1);
    drain();

    // Full / overflow, then a coalescing request while full.
    for (int i = 0; i < 5; i++) tick(1, 59'h100 + 59'(i), rnd256(), 0);
    tick(1, 59'h102, rnd256(), 0);
    tick(0, '0, '0, 0);
    drain();

    // Random traffic over a small address set to exercise coalescing and full.
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 9) < 4, 59'($urandom_range(0, 7)), rnd256(),
           $urandom_range(0, 9) < 7);
    end
    drain();

    // Asynchronous reset while beat 2 is on the bus.
    tick(1, 59'h55, rnd256(), 1);
    n = 0;
    while (!(m_send && m_beat == 2) && n < 20) begin
      tick(0, '0, '0, 1);
      n++;
    end
    chk("reach_beat2", 64'(m_beat), 64'd2);
    in_bus_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    mq.delete();
    exp_q.delete();
    m_send = 0;
    m_beat = 0;
    m_ovf  = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Traffic after reset starts from an empty queue.
    tick(1, 59'h7, rnd256(), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
